uart_tx: RTL and testbench

Transmit half of the UART link: accepts bytes from the CPU-side bus through a valid/ready handshake and serialises them onto `tx` as 8N1 frames (1 start, 8 data LSB-first, 1 stop), no parity. A small FIFO decouples the writer from the line rate. Byte frames go back-to-back with no idle gap while the FIFO is non-empty. Bit timing matches the receive path: 104 clocks per bit, so the two halves loop back cleanly.

---
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Function : 8N1 UART transmitter. A small byte FIFO is drained onto the line
//            with back-to-back frames while the FIFO has data.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int TICKS_PER_BAUD = 104,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_data_valid,
    output logic                          tx_data_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TICKS_PER_BAUD);

    localparam logic [PTR_W:0]   c_full      = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] c_last_tick = CNT_W'(TICKS_PER_BAUD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic               w_push;
    logic               w_pop;
    logic               w_baud_done;

    assign w_baud_done = (r_baud_cnt == c_last_tick);
    assign w_push      = tx_data_valid && tx_data_ready;
    // A pop only ever happens when a new frame starts: from IDLE, or at the
    // end of a stop bit so the next start bit follows without a gap.
    assign w_pop       = (r_count != '0) &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));

    assign tx_data_ready = reset_n && (r_count < c_full);
    assign tx            = r_tx;
    assign tx_busy       = (r_state != IDLE) || (r_count != '0);
    assign fifo_count    = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rd_ptr];
                        r_tx       <= 1'b0;
                        r_baud_cnt <= '0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_tx       <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_bit_idx  <= '0;
                        r_baud_cnt <= '0;
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Function : Directed self-checking bench for uart_tx (8N1, 104 clocks/bit).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int T = 104;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_data_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    uart_tx #(
        .TICKS_PER_BAUD (T),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_data       = b;
        tx_data_valid = 1'b1;
        step();
        tx_data_valid = 1'b0;
    endtask

    // Caller sits on frame cycle first_c-1; every cycle up to the last stop
    // cycle is compared against the ideal 8N1 waveform.
    task automatic expect_frame(input logic [7:0] b, input int first_c);
        logic [9:0] bits;
        logic [9:0] wrong;
        logic [9:0] seen;
        bits  = {1'b1, b, 1'b0};
        wrong = '0;
        seen  = '0;
        for (int c = first_c; c < 10*T; c++) begin
            step();
            if (tx !== bits[c/T]) begin
                wrong[c/T] = 1'b1;
                seen[c/T]  = tx;
            end
        end
        for (int i = first_c/T; i < 10; i++) begin
            total++;
            if (wrong[i]) begin
                bad++;
                $display("FAIL frame_%02h_bit%0d: tx=%b expected %b", b, i, seen[i], bits[i]);
            end
        end
    endtask

    // Receiver-style decode: find the start bit, then sample mid-bit.
    task automatic rx_byte(output logic [7:0] d, output logic frame_ok, output logic timeout);
        int n;
        n        = 0;
        d        = '0;
        frame_ok = 1'b1;
        timeout  = 1'b0;
        while (tx !== 1'b0 && n < 20*T) begin
            step();
            n++;
        end
        if (n >= 20*T) begin
            timeout = 1'b1;
            return;
        end
        repeat (T/2) step();
        if (tx !== 1'b0) frame_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (T) step();
            d[i] = tx;
        end
        repeat (T) step();
        if (tx !== 1'b1) frame_ok = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", tx_data_ready); end
        reset_n = 1'b1;
        #1;
        total++; if (tx_data_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_high: got %b want 1", tx_data_ready); end
        step();
    endtask

    task automatic test_single();
        push(8'h55);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_latency: tx=%b want 1 on accept edge", tx); end
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_on: got %b want 1", tx_busy); end
        expect_frame(8'h55, 0);
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_stop: got %b want 1", tx_busy); end
        step();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_off: got %b want 0", tx_busy); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_idle_line: got %b want 1", tx); end
    endtask

    task automatic test_back_to_back();
        push(8'h01);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL b2b_count_first: got %0d want 1", fifo_count); end
        push(8'h80);
        push(8'hFF);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count_third: got %0d want 2", fifo_count); end
        expect_frame(8'h01, 2);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count_end1: got %0d want 2", fifo_count); end
        expect_frame(8'h80, 0);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL b2b_count_end2: got %0d want 1", fifo_count); end
        expect_frame(8'hFF, 0);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL b2b_count_end3: got %0d want 0", fifo_count); end
        step();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_off: got %b want 0", tx_busy); end
    endtask

    task automatic test_full();
        logic [7:0] b [6];
        int acc;
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
        b[3] = 8'h44; b[4] = 8'h66; b[5] = 8'h77;
        acc = 0;
        tx_data       = b[0];
        tx_data_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic r;
            r = tx_data_ready;
            step();
            if (r) begin
                acc++;
                tx_data = b[acc];
            end
        end
        total++; if (acc !== 5) begin bad++; $display("FAIL full_accepted: got %0d want 5", acc); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        total++; if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b want 0", tx_data_ready); end
        expect_frame(b[0], 4);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_no_push: got %0d want 4", fifo_count); end
        step();
        total++; if (fifo_count !== 3'd3) begin bad++; $display("FAIL full_pop_edge: got %0d want 3", fifo_count); end
        total++; if (tx_data_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back: got %b want 1", tx_data_ready); end
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL full_b2b_start: got %b want 0", tx); end
        step();
        tx_data_valid = 1'b0;
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_refill: got %0d want 4", fifo_count); end
        expect_frame(b[1], 2);
        for (int k = 2; k < 6; k++) expect_frame(b[k], 0);
        step();
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL full_drained: got %b want 0", tx_busy); end
    endtask

    task automatic test_reset_mid();
        int bad_cycles;
        push(8'hA1);
        push(8'hB2);
        push(8'hC3);
        repeat (4*T) step();
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", tx_busy); end
        reset_n = 1'b0;
        #1;
        total++; if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL mid_ready_in_reset: got %b want 0", tx_data_ready); end
        step();
        reset_n = 1'b1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx: got %b want 1", tx); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", tx_busy); end
        bad_cycles = 0;
        for (int c = 0; c < 20*T; c++) begin
            step();
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad_cycles++;
        end
        total++; if (bad_cycles !== 0) begin bad++; $display("FAIL mid_quiet: got %0d active cycles want 0", bad_cycles); end
    endtask

    task automatic test_loopback();
        logic [7:0] exp_b [2];
        logic [7:0] d;
        logic ok;
        logic to;
        exp_b[0] = 8'hA5;
        exp_b[1] = 8'h3C;
        push(exp_b[0]);
        push(exp_b[1]);
        for (int k = 0; k < 2; k++) begin
            rx_byte(d, ok, to);
            total++; if (to !== 1'b0) begin bad++; $display("FAIL loop_timeout%0d: got %b want 0", k, to); end
            total++; if (d !== exp_b[k]) begin bad++; $display("FAIL loop_data%0d: got %02h want %02h", k, d, exp_b[k]); end
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL loop_framing%0d: got %b want 1", k, ok); end
        end
        repeat (2*T) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
